// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer -- memory-mapped down-counting timer with interrupt.
//
// Register map (indexed by addr[3:2]):
//   0 CTRL     bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x one-shot),
//              bit3 IM (interrupt mask/enable); bits[31:4] read 0.
//   1 PRESET   32-bit reload value, read/write.
//   2 COUNT    32-bit current count, read-only.
//   3 PRESCALE 8-bit divider when TIMER_PRESCALE_EN is defined, else reads 0.
//
// Build option:
//   TIMER_PRESCALE_EN  adds the PRESCALE register; COUNT then steps once
//                      every PRESCALE+1 cycles while counting.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous active-low reset
//   sel           device select, qualifies writes
//   addr          CPU byte address (only [3:2] decoded)
//   write_enable  CPU store strobe
//   write_data    CPU store data
//   read_result   combinational read data for addr[3:2]
//   irq           interrupt request, IM && irq_flag (driven from registers)
// -----------------------------------------------------------------------------
module timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_result,
    output logic        irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_PSC    = 2'd3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    logic [1:0]  r_state;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic [1:0]  w_idx;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_tick;
    logic        w_expire;
    logic        w_unused;

    assign w_idx       = addr[3:2];
    assign w_wr        = sel & write_enable;
    assign w_wr_ctrl   = w_wr && (w_idx == ADDR_CTRL);
    assign w_wr_preset = w_wr && (w_idx == ADDR_PRESET);
    assign w_unused    = ^{addr[31:4], addr[1:0]};

`ifdef TIMER_PRESCALE_EN
    logic [7:0] r_prescale;
    logic [7:0] r_psc_cnt;
    logic       w_wr_psc;

    assign w_wr_psc = w_wr && (w_idx == ADDR_PSC);
    // >= rather than == so that lowering PRESCALE mid-count cannot
    // make the divider run all the way around 8 bits.
    assign w_tick   = (r_psc_cnt >= r_prescale);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prescale <= 8'd0;
        end else if (w_wr_psc) begin
            r_prescale <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_psc_cnt <= 8'd0;
        end else if (r_state == ST_LOAD) begin
            r_psc_cnt <= 8'd0;
        end else if ((r_state == ST_CNT) && r_en) begin
            r_psc_cnt <= w_tick ? 8'd0 : r_psc_cnt + 8'd1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // Counter reaches its terminal step this cycle: COUNT<=1 with a
    // (possibly prescaled) decrement due.
    assign w_expire = (r_state == ST_CNT) && r_en && w_tick && (r_count <= 32'd1);

    // CTRL register. A CPU write beats the one-shot EN clear from INT,
    // so software re-arming on that exact edge is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en   <= 1'b0;
            r_mode <= 2'b00;
            r_im   <= 1'b0;
        end else if (w_wr_ctrl) begin
            // NOTE: state registers use non-blocking assignments so every
            // always_ff block samples the pre-edge values of its peers.
            r_en   <= write_data[0];
            r_mode <= write_data[2:1];
            r_im   <= write_data[3];
        end else if ((r_state == ST_INT) && (r_mode != MODE_RELOAD)) begin
            r_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_preset <= 32'd0;
        end else if (w_wr_preset) begin
            r_preset <= write_data;
        end
    end

    // Interrupt flag: a new expiry wins over a simultaneous clearing write
    // so an event is never dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq_flag <= 1'b0;
        end else if (w_expire) begin
            r_irq_flag <= 1'b1;
        end else if (w_wr_ctrl || w_wr_preset) begin
            r_irq_flag <= 1'b0;
        end else if ((r_state == ST_INT) && (r_mode == MODE_RELOAD)) begin
            r_irq_flag <= 1'b0;
        end
    end

    // Main FSM and COUNT register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_count <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_en) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_count <= r_preset;
                    r_state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!r_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        // COUNT<=1 (including a PRESET of 0) terminates at 0,
                        // so the unsigned count never wraps.
                        if (r_count > 32'd1) begin
                            r_count <= r_count - 32'd1;
                        end else begin
                            r_count <= 32'd0;
                            r_state <= ST_INT;
                        end
                    end
                end
                default: begin
                    r_state <= (r_mode == MODE_RELOAD) ? ST_LOAD : ST_IDLE;
                end
            endcase
        end
    end

    // Both operands are registers, so irq has no path from the bus.
    assign irq = r_im & r_irq_flag;

    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        read_result = 32'd0;
        case (w_idx)
            ADDR_CTRL:   read_result = {28'd0, r_im, r_mode, r_en};
            ADDR_PRESET: read_result = r_preset;
            ADDR_COUNT:  read_result = r_count;
`ifdef TIMER_PRESCALE_EN
            ADDR_PSC:    read_result = {24'd0, r_prescale};
`endif
            default:     read_result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer.sv
// -----------------------------------------------------------------------------
// tb_timer -- directed self-checking bench for timer.
// Writes are launched on the falling edge and land on the next rising edge
// ("edge 0" of each sequence); outputs are sampled 1 ns after rising edges.
// Build with TIMER_PRESCALE_EN defined to exercise the PRESCALE register.
// -----------------------------------------------------------------------------
module tb_timer;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_PSC    = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_result;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    timer dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .addr         (addr),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_result  (read_result),
        .irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] idx, input logic [31:0] d,
                          input logic s, input logic we);
        @(negedge clk);
        sel          = s;
        write_enable = we;
        addr         = {28'd0, idx, 2'b00};
        write_data   = d;
        @(posedge clk);
        #1;
        sel          = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        addr = {28'd0, idx, 2'b00};
        #1;
        check(tag, read_result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk_reg("rst_ctrl", A_CTRL, 32'd0);
        chk_reg("rst_preset", A_PRESET, 32'd0);
        chk_reg("rst_count", A_COUNT, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- test 1: one-shot ----------------
        bus_wr(A_PRESET, 32'd5, 1'b1, 1'b1);
        bus_wr(A_CTRL, 32'h9, 1'b1, 1'b1);               // edge 0
        tick();                                          // edge 1
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk_reg($sformatf("t1_count_e%0d", k), A_COUNT, 32'(7 - k));
            check($sformatf("t1_irq_e%0d", k), {31'd0, irq}, 32'd0);
        end
        tick();                                          // edge 7
        check("t1_irq_e7", {31'd0, irq}, 32'd1);
        chk_reg("t1_count_e7", A_COUNT, 32'd0);
        tick();                                          // edge 8
        chk_reg("t1_ctrl_en_cleared", A_CTRL, 32'h8);
        repeat (3) tick();
        check("t1_irq_held", {31'd0, irq}, 32'd1);
        bus_wr(A_CTRL, 32'd0, 1'b1, 1'b1);
        check("t1_irq_cleared", {31'd0, irq}, 32'd0);

        // ---------------- test 2: auto-reload ----------------
        bus_wr(A_PRESET, 32'd3, 1'b1, 1'b1);
        bus_wr(A_CTRL, 32'hB, 1'b1, 1'b1);               // edge 0
        tick();                                          // edge 1
        for (int e = 2; e <= 20; e++) begin
            tick();
            check($sformatf("t2_irq_e%0d", e), {31'd0, irq},
                  (e % 5 == 0) ? 32'd1 : 32'd0);
            if (e == 2 || e == 7 || e == 12)
                chk_reg($sformatf("t2_reload_e%0d", e), A_COUNT, 32'd3);
        end
        bus_wr(A_CTRL, 32'd0, 1'b1, 1'b1);
        repeat (3) tick();

        // ---------------- test 3: PRESET of 0, masking ----------------
        bus_wr(A_PRESET, 32'd0, 1'b1, 1'b1);
        bus_wr(A_CTRL, 32'h9, 1'b1, 1'b1);               // edge 0
        tick();
        check("t3_irq_e1", {31'd0, irq}, 32'd0);
        tick();
        check("t3_irq_e2", {31'd0, irq}, 32'd0);
        chk_reg("t3_count_e2", A_COUNT, 32'd0);
        tick();
        check("t3_irq_e3", {31'd0, irq}, 32'd1);
        tick();
        chk_reg("t3_ctrl_e4", A_CTRL, 32'h8);
        bus_wr(A_CTRL, 32'd0, 1'b1, 1'b1);
        check("t3_irq_cleared", {31'd0, irq}, 32'd0);
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b1);               // IM=0
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("t3_masked_irq_e%0d", e), {31'd0, irq}, 32'd0);
        end
        chk_reg("t3_masked_count", A_COUNT, 32'd0);
        chk_reg("t3_masked_ctrl", A_CTRL, 32'd0);
        bus_wr(A_CTRL, 32'h8, 1'b1, 1'b1);               // unmask, write clears flag
        check("t3_unmask_irq", {31'd0, irq}, 32'd0);
        chk_reg("t3_unmask_ctrl", A_CTRL, 32'h8);
        bus_wr(A_CTRL, 32'd0, 1'b1, 1'b1);

        // ---------------- test 4: freeze, preset update, reset ----------------
        bus_wr(A_PRESET, 32'd200, 1'b1, 1'b1);
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b1);               // edge 0
        repeat (50) tick();                              // edge 50
        chk_reg("t4_count_e50", A_COUNT, 32'd152);
        bus_wr(A_PRESET, 32'd500, 1'b1, 1'b1);           // edge 51
        chk_reg("t4_count_preset_wr", A_COUNT, 32'd151);
        repeat (51) tick();                              // edge 102
        chk_reg("t4_count_100", A_COUNT, 32'd100);
        bus_wr(A_CTRL, 32'd0, 1'b1, 1'b1);               // edge 103
        chk_reg("t4_count_99", A_COUNT, 32'd99);
        repeat (2) tick();
        chk_reg("t4_count_frozen", A_COUNT, 32'd99);
        chk_reg("t4_preset_500", A_PRESET, 32'd500);
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b1);               // edge 0
        repeat (2) tick();                               // edge 2
        chk_reg("t4_reload_500", A_COUNT, 32'd500);
        repeat (10) tick();
        chk_reg("t4_count_490", A_COUNT, 32'd490);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reg("t4_async_count", A_COUNT, 32'd0);
        chk_reg("t4_async_ctrl", A_CTRL, 32'd0);
        chk_reg("t4_async_preset", A_PRESET, 32'd0);
        check("t4_async_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_wr(A_PRESET, 32'd7, 1'b1, 1'b1);
        repeat (5) tick();
        chk_reg("t4_idle_count", A_COUNT, 32'd0);
        chk_reg("t4_idle_ctrl", A_CTRL, 32'd0);

        // ---------------- test 5: write qualification ----------------
        bus_wr(A_PRESET, 32'hDEAD, 1'b0, 1'b1);
        chk_reg("t5_nosel_preset", A_PRESET, 32'd7);
        bus_wr(A_CTRL, 32'h9, 1'b0, 1'b1);
        chk_reg("t5_nosel_ctrl", A_CTRL, 32'd0);
        bus_wr(A_CTRL, 32'h9, 1'b1, 1'b0);
        chk_reg("t5_nowe_ctrl", A_CTRL, 32'd0);
        repeat (4) tick();
        chk_reg("t5_count_idle", A_COUNT, 32'd0);
        bus_wr(A_COUNT, 32'h1234, 1'b1, 1'b1);
        chk_reg("t5_count_ro", A_COUNT, 32'd0);
        bus_wr(A_CTRL, 32'hFFFF_FFF8, 1'b1, 1'b1);
        chk_reg("t5_ctrl_upper", A_CTRL, 32'h8);
        bus_wr(A_CTRL, 32'd0, 1'b1, 1'b1);
        chk_reg("t5_addr3_rst", A_PSC, 32'd0);
        bus_wr(A_PSC, 32'h1FF, 1'b1, 1'b1);
`ifdef TIMER_PRESCALE_EN
        chk_reg("t5_prescale_rw", A_PSC, 32'hFF);
`else
        chk_reg("t5_addr3_reserved", A_PSC, 32'd0);
`endif

`ifdef TIMER_PRESCALE_EN
        // ---------------- test 6: prescaler ----------------
        begin
            logic [31:0] exp_c [7];
            exp_c = '{32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd0};
            bus_wr(A_PSC, 32'd2, 1'b1, 1'b1);
            chk_reg("t6_prescale", A_PSC, 32'd2);
            bus_wr(A_PRESET, 32'd2, 1'b1, 1'b1);
            bus_wr(A_CTRL, 32'h9, 1'b1, 1'b1);           // edge 0
            tick();                                      // edge 1
            for (int e = 2; e <= 8; e++) begin
                tick();
                chk_reg($sformatf("t6_count_e%0d", e), A_COUNT, exp_c[e - 2]);
                check($sformatf("t6_irq_e%0d", e), {31'd0, irq},
                      (e == 8) ? 32'd1 : 32'd0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
